// File: rtl/fft_output_stream_ctrl.sv
// Handshake and chain-control stage behind the 8-deep FFT output shift chain.
// Loads 8-word groups, drains them as a valid/ready stream, and counts frames.
module fft_output_stream_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int GROUPS     = 8,
  parameter int FCNT_W     = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  flush_i,
  input  logic                  grp_valid_i,
  output logic                  grp_ack_o,
  output logic                  hold_all_seg_o,
  output logic                  in_ctrl_all_seg_o,
  input  logic [DATA_WIDTH-1:0] q_in_i,
  output logic [DATA_WIDTH-1:0] out_data_o,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic                  out_last_o,
  output logic [5:0]            out_index_o,
  output logic                  frame_done_o,
  output logic [FCNT_W-1:0]     frame_cnt_o
);

  localparam int GW = (GROUPS > 1) ? $clog2(GROUPS) : 1;
  localparam logic [GW-1:0] GRP_LAST = GW'(GROUPS - 1);

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_t;

  state_t              st_q, st_d;
  logic [2:0]          word_cnt_q, word_cnt_d;
  logic [GW-1:0]       grp_cnt_q, grp_cnt_d;
  logic [FCNT_W-1:0]   frame_cnt_q, frame_cnt_d;
  logic                frame_done_q, frame_done_d;

  logic                last_word;
  logic                last_sample;

  assign last_word   = (word_cnt_q == 3'd7);
  assign last_sample = (st_q == STREAM) && last_word && (grp_cnt_q == GRP_LAST);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      st_q         <= IDLE;
      word_cnt_q   <= '0;
      grp_cnt_q    <= '0;
      frame_cnt_q  <= '0;
      frame_done_q <= 1'b0;
    end else begin
      st_q         <= st_d;
      word_cnt_q   <= word_cnt_d;
      grp_cnt_q    <= grp_cnt_d;
      frame_cnt_q  <= frame_cnt_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Control outputs are Mealy so the chain loads/shifts on the handshake edge.
  always_comb begin
    st_d              = st_q;
    word_cnt_d        = word_cnt_q;
    grp_cnt_d         = grp_cnt_q;
    frame_cnt_d       = frame_cnt_q;
    frame_done_d      = 1'b0;
    grp_ack_o         = 1'b0;
    hold_all_seg_o    = 1'b1;
    in_ctrl_all_seg_o = 1'b0;
    out_valid_o       = 1'b0;

    if (flush_i) begin
      st_d       = IDLE;
      word_cnt_d = '0;
      grp_cnt_d  = '0;
    end else begin
      unique case (st_q)
        IDLE: begin
          if (grp_valid_i) begin
            grp_ack_o         = 1'b1;
            hold_all_seg_o    = 1'b0;
            in_ctrl_all_seg_o = 1'b1;
            st_d              = STREAM;
            word_cnt_d        = '0;
          end
        end
        STREAM: begin
          out_valid_o = 1'b1;
          if (out_ready_i) begin
            if (!last_word) begin
              hold_all_seg_o = 1'b0;
              word_cnt_d     = word_cnt_q + 3'd1;
            end else begin
              word_cnt_d = '0;
              if (grp_cnt_q == GRP_LAST) begin
                grp_cnt_d    = '0;
                frame_cnt_d  = frame_cnt_q + FCNT_W'(1);
                frame_done_d = 1'b1;
              end else begin
                grp_cnt_d = grp_cnt_q + GW'(1);
              end
              // A waiting group is taken on the same edge, so the stream has no bubble.
              if (grp_valid_i) begin
                grp_ack_o         = 1'b1;
                hold_all_seg_o    = 1'b0;
                in_ctrl_all_seg_o = 1'b1;
              end else begin
                st_d = IDLE;
              end
            end
          end
        end
        default: begin
          st_d = IDLE;
        end
      endcase
    end
  end

  assign out_data_o   = q_in_i;
  assign out_last_o   = out_valid_o && last_sample;
  assign out_index_o  = 6'({grp_cnt_q, word_cnt_q});
  assign frame_done_o = frame_done_q;
  assign frame_cnt_o  = frame_cnt_q;

endmodule

// File: tb/tb_fft_output_stream_ctrl.sv
// Directed bench for fft_output_stream_ctrl with a behavioural 8-deep output chain.
// A 2-bit frame counter lets the wrap from all-ones to zero be reached quickly.
module tb_fft_output_stream_ctrl;

  localparam int DW  = 32;
  localparam int FCW = 2;
  localparam logic [31:0] PAT = 32'hA500_0000;

  logic           clk;
  logic           rst_n;
  logic           flush;
  logic           grp_valid;
  logic           grp_ack;
  logic           hold_all_seg;
  logic           in_ctrl_all_seg;
  logic [DW-1:0]  q_in;
  logic [DW-1:0]  out_data;
  logic           out_valid;
  logic           out_ready;
  logic           out_last;
  logic [5:0]     out_index;
  logic           frame_done;
  logic [FCW-1:0] frame_cnt;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  logic [DW-1:0] gdata [8];
  logic [DW-1:0] chain [8];

  fft_output_stream_ctrl #(
    .DATA_WIDTH(DW),
    .GROUPS    (8),
    .FCNT_W    (FCW)
  ) dut (
    .clk_i            (clk),
    .rst_ni           (rst_n),
    .flush_i          (flush),
    .grp_valid_i      (grp_valid),
    .grp_ack_o        (grp_ack),
    .hold_all_seg_o   (hold_all_seg),
    .in_ctrl_all_seg_o(in_ctrl_all_seg),
    .q_in_i           (q_in),
    .out_data_o       (out_data),
    .out_valid_o      (out_valid),
    .out_ready_i      (out_ready),
    .out_last_o       (out_last),
    .out_index_o      (out_index),
    .frame_done_o     (frame_done),
    .frame_cnt_o      (frame_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Output chain: segment 0 drives q_in, parallel load or shift toward segment 0.
  always @(posedge clk) begin
    if (!hold_all_seg) begin
      if (in_ctrl_all_seg) begin
        for (int k = 0; k < 8; k++) chain[k] <= gdata[k];
      end else begin
        for (int k = 0; k < 7; k++) chain[k] <= chain[k+1];
        chain[7] <= '0;
      end
    end
  end
  assign q_in = chain[0];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic fill(input int g);
    for (int k = 0; k < 8; k++) gdata[k] = PAT + 32'(g * 8 + k);
  endtask

  task automatic load_idle(input int g);
    fill(g);
    grp_valid = 1'b1;
    settle();
    chk("load_ack", {31'b0, grp_ack}, 32'd1);
    chk("load_inctrl", {31'b0, in_ctrl_all_seg}, 32'd1);
    chk("load_hold", {31'b0, hold_all_seg}, 32'd0);
    tick();
    grp_valid = 1'b0;
  endtask

  task automatic sample(input int idx, input bit exp_ack);
    settle();
    chk("smp_valid", {31'b0, out_valid}, 32'd1);
    chk("smp_index", {26'b0, out_index}, 32'(idx));
    chk("smp_data", out_data, PAT + 32'(idx));
    chk("smp_ack", {31'b0, grp_ack}, {31'b0, exp_ack});
    tick();
  endtask

  task automatic frame_run();
    fill(0);
    grp_valid = 1'b1;
    out_ready = 1'b1;
    settle();
    chk("frm_first_ack", {31'b0, grp_ack}, 32'd1);
    tick();
    for (int i = 0; i < 64; i++) begin
      if (i % 8 == 0) begin
        if (i < 56) fill(i / 8 + 1);
        else grp_valid = 1'b0;
      end
      settle();
      chk("frm_valid", {31'b0, out_valid}, 32'd1);
      chk("frm_index", {26'b0, out_index}, 32'(i));
      chk("frm_data", out_data, PAT + 32'(i));
      chk("frm_last", {31'b0, out_last}, {31'b0, (i == 63)});
      chk("frm_ack", {31'b0, grp_ack}, {31'b0, (i % 8 == 7) && (i < 63)});
      tick();
    end
    settle();
    chk("frm_done", {31'b0, frame_done}, 32'd1);
    chk("frm_valid_after", {31'b0, out_valid}, 32'd0);
  endtask

  initial begin
    rst_n     = 1'b0;
    flush     = 1'b0;
    grp_valid = 1'b0;
    out_ready = 1'b0;
    for (int k = 0; k < 8; k++) gdata[k] = '0;

    // Reset values
    #12;
    chk("rst_hold", {31'b0, hold_all_seg}, 32'd1);
    chk("rst_inctrl", {31'b0, in_ctrl_all_seg}, 32'd0);
    chk("rst_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_ack", {31'b0, grp_ack}, 32'd0);
    chk("rst_last", {31'b0, out_last}, 32'd0);
    chk("rst_index", {26'b0, out_index}, 32'd0);
    chk("rst_done", {31'b0, frame_done}, 32'd0);
    chk("rst_fcnt", {30'b0, frame_cnt}, 32'd0);
    rst_n = 1'b1;
    tick();

    // IDLE ignores out_ready toggling
    out_ready = 1'b1;
    settle();
    chk("idle_valid", {31'b0, out_valid}, 32'd0);
    chk("idle_hold", {31'b0, hold_all_seg}, 32'd1);
    tick();

    // Single group with D0..D7 = 1..8
    for (int k = 0; k < 8; k++) gdata[k] = 32'(k + 1);
    grp_valid = 1'b1;
    settle();
    chk("g1_ack", {31'b0, grp_ack}, 32'd1);
    chk("g1_inctrl", {31'b0, in_ctrl_all_seg}, 32'd1);
    tick();
    grp_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      settle();
      chk("g1_valid", {31'b0, out_valid}, 32'd1);
      chk("g1_data", out_data, 32'(k + 1));
      chk("g1_index", {26'b0, out_index}, 32'(k));
      chk("g1_ack_off", {31'b0, grp_ack}, 32'd0);
      tick();
    end
    settle();
    chk("g1_idle_valid", {31'b0, out_valid}, 32'd0);
    chk("g1_idle_hold", {31'b0, hold_all_seg}, 32'd1);

    // Flush in IDLE returns group counter to 0
    flush = 1'b1;
    tick();
    flush = 1'b0;
    settle();
    chk("fl_idle_index", {26'b0, out_index}, 32'd0);
    tick();

    // Full frame of back-to-back groups
    frame_run();
    chk("frm_fcnt", {30'b0, frame_cnt}, 32'd1);
    tick();
    settle();
    chk("frm_done_once", {31'b0, frame_done}, 32'd0);
    tick();

    // Stall at word 3
    out_ready = 1'b1;
    load_idle(0);
    sample(0, 1'b0);
    sample(1, 1'b0);
    sample(2, 1'b0);
    out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      settle();
      chk("st_hold", {31'b0, hold_all_seg}, 32'd1);
      chk("st_data", out_data, PAT + 32'd3);
      chk("st_index", {26'b0, out_index}, 32'd3);
      chk("st_ack", {31'b0, grp_ack}, 32'd0);
      tick();
    end
    out_ready = 1'b1;
    for (int k = 3; k < 8; k++) sample(k, 1'b0);
    settle();
    chk("st_end_valid", {31'b0, out_valid}, 32'd0);

    // Group request mid-drain waits for the word-7 handshake
    load_idle(1);
    sample(8, 1'b0);
    sample(9, 1'b0);
    fill(2);
    grp_valid = 1'b1;
    for (int k = 10; k < 15; k++) sample(k, 1'b0);
    settle();
    chk("mid_ack_inctrl", {31'b0, in_ctrl_all_seg}, 32'd1);
    chk("mid_ack_hold", {31'b0, hold_all_seg}, 32'd0);
    sample(15, 1'b1);
    grp_valid = 1'b0;

    // Flush at sample 20
    for (int k = 16; k < 20; k++) sample(k, 1'b0);
    settle();
    chk("pre_fl_index", {26'b0, out_index}, 32'd20);
    flush = 1'b1;
    grp_valid = 1'b1;
    settle();
    chk("fl_valid", {31'b0, out_valid}, 32'd0);
    chk("fl_ack", {31'b0, grp_ack}, 32'd0);
    chk("fl_hold", {31'b0, hold_all_seg}, 32'd1);
    tick();
    flush = 1'b0;
    grp_valid = 1'b0;
    settle();
    chk("fl_after_valid", {31'b0, out_valid}, 32'd0);
    chk("fl_after_index", {26'b0, out_index}, 32'd0);
    chk("fl_fcnt", {30'b0, frame_cnt}, 32'd1);
    tick();
    load_idle(0);
    for (int k = 0; k < 8; k++) sample(k, 1'b0);

    // Reach sample 40, then reset asynchronously mid-cycle
    for (int g = 1; g < 5; g++) begin
      load_idle(g);
      for (int k = 0; k < 8; k++) sample(g * 8 + k, 1'b0);
    end
    load_idle(5);
    settle();
    chk("pre_rst_index", {26'b0, out_index}, 32'd40);
    rst_n = 1'b0;
    #1;
    chk("arst_valid", {31'b0, out_valid}, 32'd0);
    chk("arst_hold", {31'b0, hold_all_seg}, 32'd1);
    chk("arst_index", {26'b0, out_index}, 32'd0);
    chk("arst_fcnt", {30'b0, frame_cnt}, 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Complete frames after reset; counter wraps 3 -> 0
    frame_run();
    chk("post_rst_fcnt", {30'b0, frame_cnt}, 32'd1);
    tick();
    frame_run();
    chk("fcnt_2", {30'b0, frame_cnt}, 32'd2);
    tick();
    frame_run();
    chk("fcnt_3", {30'b0, frame_cnt}, 32'd3);
    tick();
    frame_run();
    chk("fcnt_wrap", {30'b0, frame_cnt}, 32'd0);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
